// File: rtl/alu_issue.sv
// alu_issue: four-state issue sequencer (IDLE/OPND/EXEC/WB) driving an external 4-bit ALU from an 8x4 register file
// Ports: clk, reset (async, active-high); instr_valid/instr_ready handshake with instr_op/instr_rd/instr_rs/instr_imm/imm;
//        wr_en/wr_addr/wr_data register load port (IDLE only); alu_a/alu_b/alu_op to the ALU, alu_c/alu_flags back from it;
//        flags_q architectural flags {Z,C,F,L,N}; done writeback strobe; rd_addr/rd_data combinational read port.
// Macro ALU_ISSUE_IMM_EN: when defined, a captured immediate replaces rf[rs] as operand B if instr_imm was set.
module alu_issue (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [1:0] instr_op,
  input  logic [2:0] instr_rd,
  input  logic [2:0] instr_rs,
  input  logic       instr_imm,
  input  logic [3:0] imm,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_c,
  input  logic [4:0] alu_flags,
  output logic [4:0] flags_q,
  output logic       done,
  input  logic [2:0] rd_addr,
  output logic [3:0] rd_data
);
  typedef enum logic [1:0] {IDLE, OPND, EXEC, WB} state_t;
  state_t state, state_nx;
  logic [3:0] rf [8];
  logic [1:0] op_q;
  logic [2:0] rd_q, rs_q;
  logic [3:0] res_q, opb;
  logic [4:0] flg_q;
  assign rd_data = rf[rd_addr];
`ifdef ALU_ISSUE_IMM_EN
  logic       imm_sel_q;
  logic [3:0] imm_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      imm_sel_q <= 1'b0;
      imm_q <= '0;
    end else if (state == IDLE && instr_valid) begin
      imm_sel_q <= instr_imm;
      imm_q <= imm;
    end
  assign opb = imm_sel_q ? imm_q : rf[rs_q];
`else
  logic unused_imm;
  assign unused_imm = ^{instr_imm, imm};
  assign opb = rf[rs_q];
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    instr_ready = state == IDLE;
    done = state == WB;
    state_nx = state == IDLE ? (instr_valid ? OPND : IDLE) :
               state == OPND ? EXEC :
               state == EXEC ? WB : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op_q <= '0;
      rd_q <= '0;
      rs_q <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      res_q <= '0;
      flg_q <= '0;
      flags_q <= '0;
    end else begin
      if (state == IDLE && instr_valid) begin
        op_q <= instr_op;
        rd_q <= instr_rd;
        rs_q <= instr_rs;
      end
      if (state == OPND) begin
        alu_a <= rf[rd_q];
        alu_b <= opb;
        alu_op <= op_q;
      end
      if (state == EXEC) begin
        res_q <= alu_c;
        flg_q <= alu_flags;
      end
      if (state == WB) flags_q <= flg_q;
    end
  // Load-port writes and writeback never collide: loads only land in IDLE, writeback only in WB.
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < 8; i++) rf[i] <= '0;
    else if (state == IDLE && wr_en) rf[wr_addr] <= wr_data;
    else if (state == WB && op_q != 2'b11) rf[rd_q] <= res_q;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: randomized and directed bench for alu_issue against a transaction-level model
module tb_alu_issue;
`ifdef ALU_ISSUE_IMM_EN
  localparam bit IMM = 1'b1;
`else
  localparam bit IMM = 1'b0;
`endif
  logic clk, reset, instr_valid, instr_ready, instr_imm, wr_en, done;
  logic [1:0] instr_op, alu_op;
  logic [2:0] instr_rd, instr_rs, wr_addr, rd_addr;
  logic [3:0] imm, wr_data, alu_a, alu_b, alu_c, rd_data;
  logic [4:0] alu_flags, flags_q;
  int checks = 0, errors = 0, dones = 0, cnt = 0;
  bit started = 0;
  logic [3:0] m_rf [8];
  logic [4:0] m_flags, e_flg;
  logic [3:0] e_a, e_b, e_res;
  logic [1:0] e_op;
  logic [2:0] e_rd;

  alu_issue dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_imm(instr_imm), .imm(imm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c), .alu_flags(alu_flags),
    .flags_q(flags_q), .done(done), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // External ALU: returns {Z,C,F,L,N, result}. ADDU: Z,C. ADD: Z,C,F (signed overflow). SUB: Z, C=borrow.
  // CMP: Z=(a==b), L=a above b unsigned, N=a below b signed.
  function automatic logic [8:0] alu_ref(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    logic z, cy, f, l, n;
    s = (op == 2'd0 || op == 2'd1) ? {1'b0, a} + {1'b0, b} : {1'b0, a} - {1'b0, b};
    z = (op == 2'd3) ? (a == b) : (s[3:0] == 4'd0);
    cy = (op == 2'd0 || op == 2'd1) ? s[4] : (op == 2'd2) ? (a < b) : 1'b0;
    f = (op == 2'd1) && (a[3] == b[3]) && (s[3] != a[3]);
    l = (op == 2'd3) && (a > b);
    n = (op == 2'd3) && ($signed(a) < $signed(b));
    return {z, cy, f, l, n, s[3:0]};
  endfunction

  always_comb {alu_flags, alu_c} = alu_ref(alu_op, alu_a, alu_b);

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted instruction is fully evaluated at accept time (the register file
  // cannot change while busy), shows done three edges later and commits on the fourth.
  task automatic tick();
    @(posedge clk);
    if (cnt == 3) begin
      m_flags = e_flg;
      if (e_op != 2'd3) m_rf[e_rd] = e_res;
      cnt = 0;
    end else if (cnt != 0) cnt++;
    else begin
      if (wr_en) m_rf[wr_addr] = wr_data;
      if (instr_valid) begin
        e_a = m_rf[instr_rd];
        e_b = (IMM && instr_imm) ? imm : m_rf[instr_rs];
        e_op = instr_op;
        e_rd = instr_rd;
        {e_flg, e_res} = alu_ref(e_op, e_a, e_b);
        cnt = 1;
      end
    end
    #1;
    dones += int'(done);
  endtask

  always @(negedge clk) if (started) begin
    chk("ready", 8'(instr_ready), 8'(cnt == 0));
    chk("done", 8'(done), 8'(cnt == 3));
    chk("flags_q", 8'(flags_q), 8'(m_flags));
    chk("rd_data", 8'(rd_data), 8'(m_rf[rd_addr]));
    if (cnt >= 2) begin
      chk("alu_a", 8'(alu_a), 8'(e_a));
      chk("alu_b", 8'(alu_b), 8'(e_b));
      chk("alu_op", 8'(alu_op), 8'(e_op));
    end
  end

  task automatic do_reset();
    reset = 1;
    instr_valid = 0;
    wr_en = 0;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    m_flags = '0;
    cnt = 0;
    #1;
    chk("rst_ready", 8'(instr_ready), 8'd1);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_flags", 8'(flags_q), 8'd0);
    chk("rst_alu", 8'({alu_a, alu_b, alu_op} != 10'd0), 8'd0);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1;
      chk("rst_rf", 8'(rd_data), 8'd0);
    end
    @(negedge clk);
    reset = 0;
  endtask

  task automatic load(input logic [2:0] a, input logic [3:0] d);
    wr_en = 1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic isel, input logic [3:0] iv);
    instr_valid = 1;
    instr_op = op;
    instr_rd = rd;
    instr_rs = rs;
    instr_imm = isel;
    imm = iv;
    tick();
    instr_valid = 0;
    repeat (3) begin
      instr_op = 2'($urandom);
      instr_rd = 3'($urandom);
      instr_rs = 3'($urandom);
      instr_imm = 1'($urandom);
      imm = 4'($urandom);
      tick();
    end
  endtask

  task automatic rdchk(input string nm, input logic [2:0] a, input logic [3:0] e);
    rd_addr = a;
    #1;
    chk(nm, 8'(rd_data), 8'(e));
  endtask

  initial begin
    {instr_valid, instr_op, instr_rd, instr_rs, instr_imm, imm, wr_en, wr_addr, wr_data, rd_addr} = '0;
    do_reset();
    started = 1;
    dones = 0;
    load(1, 4'd7); load(2, 4'd9);
    issue(2'd0, 1, 2, 0, 0);
    rdchk("addu_r1", 1, 4'd0);
    chk("addu_flags", 8'(flags_q), 8'b11000);
    chk("addu_dones", 8'(dones), 8'd1);
    load(1, 4'd5); load(2, 4'd4);
    issue(2'd1, 1, 2, 0, 0);
    rdchk("add_r1", 1, 4'd9);
    chk("add_flags", 8'(flags_q), 8'b00100);
    issue(2'd2, 1, 2, 0, 0);
    rdchk("sub_r1", 1, 4'd5);
    chk("sub_flags", 8'(flags_q), 8'b00000);
    load(1, 4'hE); load(2, 4'd2);
    issue(2'd3, 1, 2, 0, 0);
    chk("cmp_flags", 8'(flags_q), 8'b00011);
    rdchk("cmp_r1", 1, 4'hE);
    issue(2'd3, 2, 1, 0, 0);
    chk("cmp_swap_flags", 8'(flags_q), 8'b00000);
    wr_en = 1; wr_addr = 2; wr_data = 4'd3;
    issue(2'd0, 1, 2, 0, 0);
    rdchk("wr_accept_r1", 1, 4'd1);
    load(4, 4'd6);
    issue(2'd0, 4, 4, 0, 0);
    rdchk("rd_eq_rs_r4", 4, 4'hC);
    load(1, 4'd5); load(2, 4'd4);
    dones = 0;
    instr_valid = 1; instr_op = 2'd1; instr_rd = 1; instr_rs = 2;
    tick();
    instr_valid = 0;
    tick();
    do_reset();
    repeat (4) tick();
    chk("abort_dones", 8'(dones), 8'd0);
    rdchk("abort_r1", 1, 4'd0);
    dones = 0;
    instr_valid = 1;
    repeat (16) begin
      instr_op = 2'($urandom); instr_rd = 3'($urandom); instr_rs = 3'($urandom);
      wr_en = 1; wr_addr = 3'($urandom); wr_data = 4'($urandom); rd_addr = 3'($urandom);
      tick();
    end
    instr_valid = 0; wr_en = 0;
    chk("stream_dones", 8'(dones), 8'd4);
`ifdef ALU_ISSUE_IMM_EN
    load(3, 4'd3);
    issue(2'd2, 3, 0, 1, 4'd3);
    rdchk("imm_r3", 3, 4'd0);
    chk("imm_flags", 8'(flags_q), 8'b10000);
`else
    load(0, 4'd1); load(3, 4'd3);
    issue(2'd2, 3, 0, 1, 4'd3);
    rdchk("noimm_r3", 3, 4'd2);
    chk("noimm_flags", 8'(flags_q), 8'b00000);
`endif
    repeat (600) begin
      if ($urandom_range(0, 80) == 0) do_reset();
      instr_valid = 1'($urandom);
      instr_op = 2'($urandom); instr_rd = 3'($urandom); instr_rs = 3'($urandom);
      instr_imm = 1'($urandom); imm = 4'($urandom);
      wr_en = ($urandom_range(0, 2) == 0); wr_addr = 3'($urandom); wr_data = 4'($urandom);
      rd_addr = 3'($urandom);
      tick();
    end
    instr_valid = 0;
    wr_en = 0;
    repeat (4) tick();
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
